// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_pkg
// Purpose : Shared definitions for the decode-stage hazard controller:
//           branch FSM state encoding, the default issue-to-writeback
//           distance, and the scoreboard counter width helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package hazard_ctrl_pkg;

  // Issue-to-writeback distance used when the parent does not override it.
  localparam int WB_DIST_DEFAULT = 3;

  // RUN: normal issue.  BR_WAIT: a branch/jump is unresolved and IF/ID
  // holds wrong-path contents.
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_t;

  // Width of one scoreboard countdown. The largest value loaded is
  // WB_DIST-1, so clog2(WB_DIST) bits always suffice for the legal range.
  function automatic int cnt_w(input int wb_dist);
    return $clog2(wb_dist);
  endfunction

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_if
// Purpose : Decode-side bundle between the pipeline and the hazard
//           controller. The pipeline (master) drives the decoded
//           instruction fields and the resolve pulse; the controller
//           (slave) returns issue/stall/squash decisions and status.
// Ports   : master -> id_valid, id_rs_sel, id_rs_used, id_rt_sel,
//                     id_rt_used, id_wr_en, id_wr_addr, id_is_ctrl,
//                     ex_ctrl_resolved
//           slave  -> issue, bubble, stall_id, fetch_hold, id_squash,
//                     busy_mask, err
// Rev     : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int AW   = 3,
  parameter int NREG = 8
);

  logic            id_valid;
  logic [AW-1:0]   id_rs_sel;
  logic            id_rs_used;
  logic [AW-1:0]   id_rt_sel;
  logic            id_rt_used;
  logic            id_wr_en;
  logic [AW-1:0]   id_wr_addr;
  logic            id_is_ctrl;
  logic            ex_ctrl_resolved;

  logic            issue;
  logic            bubble;
  logic            stall_id;
  logic            fetch_hold;
  logic            id_squash;
  logic [NREG-1:0] busy_mask;
  logic            err;

  modport master (
    output id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used,
           id_wr_en, id_wr_addr, id_is_ctrl, ex_ctrl_resolved,
    input  issue, bubble, stall_id, fetch_hold, id_squash, busy_mask, err
  );

  modport slave (
    input  id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used,
           id_wr_en, id_wr_addr, id_is_ctrl, ex_ctrl_resolved,
    output issue, bubble, stall_id, fetch_hold, id_squash, busy_mask, err
  );

endinterface : hazard_ctrl_if
`default_nettype wire

// File: rtl/hazard_ctrl_sb_counter.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_sb_counter
// Purpose : Scoreboard entry (sb_counter) for one architectural register.
//           A load arms the countdown at WB_DIST-1; it then decrements once
//           per cycle until zero. The register is busy while nonzero.
// Ports   : clk   - clock
//           rst   - asynchronous active-low reset
//           load  - a write to this register issued this cycle
//           busy  - a write to this register is still in flight
// Rev     : 1.0  initial release
// ============================================================================
module hazard_ctrl_sb_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int WB_DIST = WB_DIST_DEFAULT
) (
  input  wire  clk,
  input  wire  rst,
  input  logic load,
  output logic busy
);

  localparam int            c_cw       = cnt_w(WB_DIST);
  localparam logic [c_cw-1:0] c_load_val = c_cw'(WB_DIST - 1);

  logic [c_cw-1:0] r_cnt;

  // A load wins over the decrement so a younger write always restarts the
  // full wait, even if the older write was about to retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= c_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_cw'(1);
    end
  end

  assign busy = (r_cnt != '0);

endmodule : hazard_ctrl_sb_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl
// Purpose : Hazard controller beside the decode stage of a non-forwarding
//           five-stage pipeline. Tracks in-flight register writes with a
//           per-register countdown scoreboard, stalls decode on RAW until
//           the source is visible through the bypassing register file, and
//           holds fetch / squashes IF/ID while a branch or jump is
//           unresolved. A resolve pulse seen with no branch outstanding
//           sets a sticky error.
// Ports   : clk  - clock, all state on rising edge
//           rst  - asynchronous active-low reset
//           bus  - hazard_ctrl_if.slave (decoded instruction in, issue /
//                  bubble / stall_id / fetch_hold / id_squash / busy_mask /
//                  err out)
// Rev     : 1.0  initial release
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NREG    = 8,
  parameter int AW      = 3,
  parameter int WB_DIST = WB_DIST_DEFAULT
) (
  input  wire          clk,
  input  wire          rst,
  hazard_ctrl_if.slave bus
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_err;
  logic            w_err_nxt;

  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_load;
  logic            w_squash;
  logic            w_rs_hit;
  logic            w_rt_hit;
  logic            w_raw;
  logic            w_issue;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  generate
    for (genvar r = 0; r < NREG; r++) begin : g_sb
      // Only an issued write arms the scoreboard; stalled or squashed
      // instructions never do.
      assign w_load[r] = w_issue & bus.id_wr_en & (bus.id_wr_addr == AW'(r));

      hazard_ctrl_sb_counter #(
        .WB_DIST (WB_DIST)
      ) u_sb_counter (
        .clk  (clk),
        .rst  (rst),
        .load (w_load[r]),
        .busy (w_busy[r])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Hazard compare
  // --------------------------------------------------------------------------
  // While a branch is outstanding IF/ID is wrong-path, so its contents
  // neither issue nor raise a RAW stall.
  assign w_squash = (r_state == BR_WAIT);

  // Lookups use the registered scoreboard only, so an instruction whose
  // source equals its own destination never stalls on itself.
  assign w_rs_hit = bus.id_rs_used & w_busy[bus.id_rs_sel];
  assign w_rt_hit = bus.id_rt_used & w_busy[bus.id_rt_sel];
  assign w_raw    = bus.id_valid & ~w_squash & (w_rs_hit | w_rt_hit);
  assign w_issue  = bus.id_valid & ~w_squash & ~w_raw;

  // --------------------------------------------------------------------------
  // Branch FSM and sticky error
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      RUN: begin
        // A resolve with nothing outstanding is a protocol violation; it is
        // recorded but otherwise ignored, even if a control instruction is
        // issuing in the same cycle (that one still enters BR_WAIT).
        if (bus.ex_ctrl_resolved) begin
          w_err_nxt = 1'b1;
        end
        if (w_issue & bus.id_is_ctrl) begin
          w_state_nxt = BR_WAIT;
        end
      end
      BR_WAIT: begin
        if (bus.ex_ctrl_resolved) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.issue      = w_issue;
  assign bus.bubble     = ~w_issue;
  assign bus.stall_id   = w_raw;
  // The PC is held while decode stalls, in the cycle a control instruction
  // leaves decode, and while waiting for resolution; in the resolve cycle
  // itself the PC takes the target so fetch resumes.
  assign bus.fetch_hold = w_raw
                        | (w_issue & bus.id_is_ctrl)
                        | (w_squash & ~bus.ex_ctrl_resolved);
  assign bus.id_squash  = w_squash;
  assign bus.busy_mask  = w_busy;
  assign bus.err        = r_err;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl
// Purpose : Self-checking bench for hazard_ctrl: reset behaviour, a table
//           of directed per-cycle vectors (RAW, reload, self-dependency,
//           branch hold/squash, error), asynchronous reset inside BR_WAIT,
//           and randomized traffic against a readiness-time reference model.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int NREG    = 8;
  localparam int AW      = 3;
  localparam int WB_DIST = 3;

  logic clk;
  logic rst;

  hazard_ctrl_if #(.AW(AW), .NREG(NREG)) bus ();

  hazard_ctrl #(
    .NREG    (NREG),
    .AW      (AW),
    .WB_DIST (WB_DIST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // {issue, bubble, stall_id, fetch_hold, id_squash, err, busy_mask}
  function automatic logic [13:0] pack_dut();
    return {bus.issue, bus.bubble, bus.stall_id, bus.fetch_hold,
            bus.id_squash, bus.err, bus.busy_mask};
  endfunction

  task automatic check(input string name, input logic [13:0] act,
                       input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got iss/bub/stl/fh/sq/err/busy=%b_%b_%b_%b_%b_%b_%h expected %b_%b_%b_%b_%b_%b_%h",
               name, act[13], act[12], act[11], act[10], act[9], act[8], act[7:0],
               exp[13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic       valid;
    logic [2:0] rs;
    logic       rs_u;
    logic [2:0] rt;
    logic       rt_u;
    logic       wr;
    logic [2:0] wa;
    logic       ctrl;
    logic       res;
    logic       e_issue;
    logic       e_stall;
    logic       e_fh;
    logic       e_sq;
    logic [7:0] e_busy;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(input int v, input int rs, input int rsu,
                              input int rt, input int rtu, input int wr,
                              input int wa, input int ctrl, input int res,
                              input int iss, input int stl, input int fh,
                              input int sq, input int busy, input int err);
    vec_t x;
    x.valid = 1'(v);    x.rs = 3'(rs);   x.rs_u = 1'(rsu);
    x.rt = 3'(rt);      x.rt_u = 1'(rtu); x.wr = 1'(wr);
    x.wa = 3'(wa);      x.ctrl = 1'(ctrl); x.res = 1'(res);
    x.e_issue = 1'(iss); x.e_stall = 1'(stl); x.e_fh = 1'(fh);
    x.e_sq = 1'(sq);    x.e_busy = 8'(busy); x.e_err = 1'(err);
    return x;
  endfunction

  task automatic drive(input logic v, input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rt, input logic rtu, input logic wr,
                       input logic [2:0] wa, input logic ctrl, input logic res);
    bus.id_valid         = v;
    bus.id_rs_sel        = rs;
    bus.id_rs_used       = rsu;
    bus.id_rt_sel        = rt;
    bus.id_rt_used       = rtu;
    bus.id_wr_en         = wr;
    bus.id_wr_addr       = wa;
    bus.id_is_ctrl       = ctrl;
    bus.ex_ctrl_resolved = res;
  endtask

  // --------------------------------------------------------------------------
  // Reference model: each register holds the cycle number from which it is
  // readable again; a branch flag and an error flag complete the state.
  // --------------------------------------------------------------------------
  int cyc;
  int ready_at[NREG];
  bit m_br;
  bit m_err;

  task automatic model_reset();
    cyc = 0;
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    m_br  = 1'b0;
    m_err = 1'b0;
  endtask

  function automatic bit m_busy(input int r);
    return cyc < ready_at[r];
  endfunction

  function automatic bit m_issue_now();
    bit hz;
    hz = (bus.id_rs_used && m_busy(int'(bus.id_rs_sel))) ||
         (bus.id_rt_used && m_busy(int'(bus.id_rt_sel)));
    return bus.id_valid && !m_br && !hz;
  endfunction

  function automatic logic [13:0] model_out();
    bit hz, iss, stl, fh;
    logic [7:0] bm;
    for (int r = 0; r < NREG; r++) bm[r] = m_busy(r);
    hz  = (bus.id_rs_used && m_busy(int'(bus.id_rs_sel))) ||
          (bus.id_rt_used && m_busy(int'(bus.id_rt_sel)));
    stl = bus.id_valid && !m_br && hz;
    iss = m_issue_now();
    fh  = stl || (iss && bus.id_is_ctrl) || (m_br && !bus.ex_ctrl_resolved);
    return {iss, !iss, stl, fh, m_br, m_err, bm};
  endfunction

  task automatic model_clock();
    bit iss;
    iss = m_issue_now();
    if (iss && bus.id_wr_en) ready_at[int'(bus.id_wr_addr)] = cyc + WB_DIST;
    if (m_br) begin
      if (bus.ex_ctrl_resolved) m_br = 1'b0;
    end else begin
      if (bus.ex_ctrl_resolved) m_err = 1'b1;
      if (iss && bus.id_is_ctrl) m_br = 1'b1;
    end
    cyc++;
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  vec_t vecs[$];

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held with inputs moving (decode kept invalid).
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(0, 3'($urandom), 1'(i), 3'($urandom), 1'(~i), 1, 3'($urandom),
            1'(~i), 1'(i));
      @(negedge clk);
      check($sformatf("in_reset%0d", i), pack_dut(), 14'b0_1_0_0_0_0_00000000);
    end

    // Release away from the edge; an instruction with no sources issues.
    @(posedge clk); #2;
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("reset_release", pack_dut(), 14'b1_0_0_0_0_0_00000000);
    @(posedge clk); #1;

    //         v rs u rt u wr wa c rs | iss stl fh sq busy  err
    vecs.push_back(mk(1,0,0,0,0,1,3,0,0, 1,0,0,0,'h00,0)); // write r3 at t
    vecs.push_back(mk(1,3,1,0,0,0,0,0,0, 0,1,1,0,'h08,0)); // t+1 stall
    vecs.push_back(mk(1,3,1,0,0,0,0,0,0, 0,1,1,0,'h08,0)); // t+2 stall
    vecs.push_back(mk(1,3,1,0,0,0,0,0,0, 1,0,0,0,'h00,0)); // t+3 issue
    vecs.push_back(mk(1,0,0,0,0,1,5,0,0, 1,0,0,0,'h00,0)); // write r5
    vecs.push_back(mk(1,0,0,0,0,1,5,0,0, 1,0,0,0,'h20,0)); // write r5 again
    vecs.push_back(mk(1,0,0,5,1,0,0,0,0, 0,1,1,0,'h20,0)); // reader stalls
    vecs.push_back(mk(1,0,0,5,1,0,0,0,0, 0,1,1,0,'h20,0));
    vecs.push_back(mk(1,0,0,5,1,0,0,0,0, 1,0,0,0,'h00,0)); // issues at t+4
    vecs.push_back(mk(1,2,1,0,0,1,2,0,0, 1,0,0,0,'h00,0)); // r2 <- f(r2)
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,'h04,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,1,0, 1,0,1,0,'h04,0)); // branch issues
    vecs.push_back(mk(1,4,1,0,0,1,4,0,0, 0,0,1,1,'h00,0)); // wrong path
    vecs.push_back(mk(1,4,1,0,0,1,4,0,0, 0,0,1,1,'h00,0));
    vecs.push_back(mk(1,4,1,0,0,1,4,0,0, 0,0,1,1,'h00,0));
    vecs.push_back(mk(1,4,1,0,0,1,4,0,1, 0,0,0,1,'h00,0)); // resolve t+4
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,0,0,'h00,0)); // back in RUN
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1, 0,0,0,0,'h00,0)); // stray resolve
    vecs.push_back(mk(1,0,0,0,0,1,1,0,0, 1,0,0,0,'h00,1)); // err sticky
    vecs.push_back(mk(1,1,1,0,0,0,0,1,0, 0,1,1,0,'h02,1)); // branch on RAW
    vecs.push_back(mk(1,1,1,0,0,0,0,1,0, 0,1,1,0,'h02,1));
    vecs.push_back(mk(1,1,1,0,0,0,0,1,0, 1,0,1,0,'h00,1)); // now issues
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,1,1,'h00,1)); // BR_WAIT

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].rs, vecs[i].rs_u, vecs[i].rt, vecs[i].rt_u,
            vecs[i].wr, vecs[i].wa, vecs[i].ctrl, vecs[i].res);
      @(negedge clk);
      check($sformatf("vec%0d", i), pack_dut(),
            {vecs[i].e_issue, ~vecs[i].e_issue, vecs[i].e_stall, vecs[i].e_fh,
             vecs[i].e_sq, vecs[i].e_err, vecs[i].e_busy});
      @(posedge clk); #1;
    end

    // Still in BR_WAIT with err set: asynchronous reset mid-cycle.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("pre_async_reset", pack_dut(), 14'b0_1_0_1_1_1_00000000);
    rst = 1'b0;
    #1;
    check("async_reset_brwait", pack_dut(), 14'b0_1_0_0_0_0_00000000);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic against the model; one reset midway.
    model_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        model_reset();
        check("rand_reset", pack_dut(), model_out());
        @(posedge clk); #2;
        rst = 1'b1;
      end
      drive(1'($urandom_range(0, 9) < 8), 3'($urandom), 1'($urandom),
            3'($urandom), 1'($urandom), 1'($urandom_range(0, 9) < 6),
            3'($urandom), 1'($urandom_range(0, 9) < 2),
            m_br ? 1'($urandom_range(0, 3) == 0)
                 : 1'($urandom_range(0, 79) == 0));
      @(negedge clk);
      check($sformatf("rand%0d", i), pack_dut(), model_out());
      model_clock();
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
